warp_ahb_arbiter: RTL

- Shares one AHB-Lite manager port between two internal requesters: port 0 (instruction fetch) and port 1 (load/store).
- Each requester uses a valid/ready request channel and a registered response pulse.
- The block drives the pipelined AHB address and data phases, tracks which requester owns the data phase, and routes responses back to that requester.
- Sits between the core front-end/LSU and the system bus.

---
 rtl/warp_ahb_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/warp_ahb_arbiter.sv
// Shares one AHB-Lite manager port between instruction fetch (port 0) and load/store (port 1).
// Define WARP_AHBARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module warp_ahb_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter logic [3:0]  HPROT_VALUE = 4'b0011
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req0_valid,
    output logic                    o_req0_ready,
    input  logic [ADDR_WIDTH-1:0]   i_req0_addr,
    input  logic                    i_req0_write,
    input  logic [2:0]              i_req0_size,
    input  logic [DATA_WIDTH-1:0]   i_req0_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req0_wstrb,
    output logic                    o_rsp0_valid,
    output logic [DATA_WIDTH-1:0]   o_rsp0_rdata,
    output logic                    o_rsp0_err,
    input  logic                    i_req1_valid,
    output logic                    o_req1_ready,
    input  logic [ADDR_WIDTH-1:0]   i_req1_addr,
    input  logic                    i_req1_write,
    input  logic [2:0]              i_req1_size,
    input  logic [DATA_WIDTH-1:0]   i_req1_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req1_wstrb,
    output logic                    o_rsp1_valid,
    output logic [DATA_WIDTH-1:0]   o_rsp1_rdata,
    output logic                    o_rsp1_err,
    output logic [ADDR_WIDTH-1:0]   o_ahb_haddr,
    output logic [2:0]              o_ahb_hburst,
    output logic                    o_ahb_hmastlock,
    output logic [3:0]              o_ahb_hprot,
    output logic [2:0]              o_ahb_hsize,
    output logic                    o_ahb_hnonsec,
    output logic                    o_ahb_hexcl,
    output logic [1:0]              o_ahb_htrans,
    output logic [DATA_WIDTH-1:0]   o_ahb_hwdata,
    output logic [DATA_WIDTH/8-1:0] o_ahb_hwstrb,
    output logic                    o_ahb_hwrite,
    input  logic [DATA_WIDTH-1:0]   i_ahb_hrdata,
    input  logic                    i_ahb_hready,
    input  logic                    i_ahb_hresp
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  grant0, grant1, grant_any;

    logic                  vld_p0, owner_p0, write_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [2:0]            size_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;
    logic [STRB_WIDTH-1:0] wstrb_p0;

    logic                  vld_p1, owner_p1, write_p1;
    logic [DATA_WIDTH-1:0] hwdata_p1;
    logic [STRB_WIDTH-1:0] hwstrb_p1;

    logic                  rsp0_vld_p2, rsp1_vld_p2, err0_p2, err1_p2;
    logic [DATA_WIDTH-1:0] rdata0_p2, rdata1_p2;

    logic                  done0, done1;
    logic [DATA_WIDTH-1:0] rdata_sel;

`ifdef WARP_AHBARB_RR_EN
    // Remembers the port of the last acceptance; reset value makes port 0 win the first tie.
    logic last_grant1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant1 <= 1'b1;
        end else if (grant_any) begin
            last_grant1 <= grant1;
        end
    end

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (i_rst_n && i_ahb_hready) begin
            if (i_req0_valid && i_req1_valid) begin
                grant0 = last_grant1;
                grant1 = !last_grant1;
            end else begin
                grant0 = i_req0_valid;
                grant1 = i_req1_valid;
            end
        end
    end
`else
    always_comb begin
        grant0 = i_rst_n && i_ahb_hready && i_req0_valid;
        grant1 = i_rst_n && i_ahb_hready && i_req1_valid && !i_req0_valid;
    end
`endif

    assign grant_any    = grant0 || grant1;
    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;

    // Stage p0: address phase, loaded from the arbitration winner on every bus advance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p0   <= 1'b0;
            owner_p0 <= 1'b0;
            write_p0 <= 1'b0;
            addr_p0  <= '0;
            size_p0  <= '0;
            wdata_p0 <= '0;
            wstrb_p0 <= '0;
        end else if (i_ahb_hready) begin
            vld_p0 <= grant_any;
            if (grant_any) begin
                owner_p0 <= grant1;
                write_p0 <= grant1 ? i_req1_write : i_req0_write;
                addr_p0  <= grant1 ? i_req1_addr  : i_req0_addr;
                size_p0  <= grant1 ? i_req1_size  : i_req0_size;
                wdata_p0 <= grant1 ? i_req1_wdata : i_req0_wdata;
                wstrb_p0 <= grant1 ? i_req1_wstrb : i_req0_wstrb;
            end
        end
    end

    // Stage p1: data phase; write data follows its address one advance later
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1    <= 1'b0;
            owner_p1  <= 1'b0;
            write_p1  <= 1'b0;
            hwdata_p1 <= '0;
            hwstrb_p1 <= '0;
        end else if (i_ahb_hready) begin
            vld_p1    <= vld_p0;
            owner_p1  <= owner_p0;
            write_p1  <= write_p0;
            hwdata_p1 <= wdata_p0;
            hwstrb_p1 <= wstrb_p0;
        end
    end

    assign done0     = i_ahb_hready && vld_p1 && !owner_p1;
    assign done1     = i_ahb_hready && vld_p1 && owner_p1;
    assign rdata_sel = write_p1 ? '0 : i_ahb_hrdata;

    // Stage p2: registered response pulse routed to the data-phase owner
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp0_vld_p2 <= 1'b0;
            rsp1_vld_p2 <= 1'b0;
            rdata0_p2   <= '0;
            rdata1_p2   <= '0;
            err0_p2     <= 1'b0;
            err1_p2     <= 1'b0;
        end else begin
            rsp0_vld_p2 <= done0;
            rsp1_vld_p2 <= done1;
            if (done0) begin
                rdata0_p2 <= rdata_sel;
                err0_p2   <= i_ahb_hresp;
            end
            if (done1) begin
                rdata1_p2 <= rdata_sel;
                err1_p2   <= i_ahb_hresp;
            end
        end
    end

    assign o_rsp0_valid    = rsp0_vld_p2;
    assign o_rsp0_rdata    = rdata0_p2;
    assign o_rsp0_err      = err0_p2;
    assign o_rsp1_valid    = rsp1_vld_p2;
    assign o_rsp1_rdata    = rdata1_p2;
    assign o_rsp1_err      = err1_p2;

    assign o_ahb_haddr     = addr_p0;
    assign o_ahb_hsize     = size_p0;
    assign o_ahb_hwrite    = write_p0;
    assign o_ahb_htrans    = {vld_p0, 1'b0};
    assign o_ahb_hwdata    = hwdata_p1;
    assign o_ahb_hwstrb    = hwstrb_p1;
    assign o_ahb_hburst    = 3'b000;
    assign o_ahb_hmastlock = 1'b0;
    assign o_ahb_hprot     = HPROT_VALUE;
    assign o_ahb_hnonsec   = 1'b0;
    assign o_ahb_hexcl     = 1'b0;

endmodule
